// File: rtl/fir_decim_fifo.sv
// Decimating sample FIFO behind a FIR output: keeps one of every DECIM valid
// samples and queues it for a ready/valid consumer, with a sticky drop flag.
module fir_decim_fifo #(
   parameter int DEPTH = 8,
   parameter int DECIM = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       in_valid,
   input  logic [3:0]                 in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [3:0]    PH_LAST  = 4'(DECIM - 1);

   logic [3:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [3:0]    r_phase;
   logic          r_ovf;

   logic w_keep;
   logic w_pop;
   logic w_write;
   logic w_drop;
   logic w_full;
   logic w_empty;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_keep  = in_valid && (r_phase == 4'd0);
   assign w_pop   = !w_empty && out_ready;
   // A full FIFO still accepts a kept sample when the head leaves this cycle.
   assign w_write = w_keep && (!w_full || w_pop);
   assign w_drop  = w_keep && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_phase <= 4'd0;
         r_ovf   <= 1'b0;
      end else begin
         if (in_valid)
            r_phase <= (r_phase == PH_LAST) ? 4'd0 : r_phase + 4'd1;
         if (w_write)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
      end
   end

   // Storage is deliberately not reset; it is only visible through a non-empty head.
   always_ff @(posedge clk) begin
      if (rstn && w_write)
         r_mem[r_wptr] <= in_data;
   end

   assign out_valid = !w_empty;
   assign out_data  = w_empty ? 4'b0000 : r_mem[r_rptr];
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: three instances (DECIM 1, 2, 3) share
// the stimulus; each section resets and checks only the instance it targets.
module tb_fir_decim_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn;
   logic       in_valid;
   logic [3:0] in_data;
   logic       out_ready;
   logic       clr_ovf;

   logic       ov1, ov2, ov3;
   logic [3:0] od1, od2, od3;
   logic [3:0] cnt1, cnt2, cnt3;
   logic       fu1, fu2, fu3;
   logic       em1, em2, em3;
   logic       of1, of2, of3;

   int errors = 0;
   int checks = 0;

   fir_decim_fifo #(.DEPTH(8), .DECIM(1)) u1 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .count(cnt1),
      .full(fu1), .empty(em1), .overflow(of1), .clr_ovf(clr_ovf));

   fir_decim_fifo #(.DEPTH(8), .DECIM(2)) u2 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(cnt2),
      .full(fu2), .empty(em2), .overflow(of2), .clr_ovf(clr_ovf));

   fir_decim_fifo #(.DEPTH(8), .DECIM(3)) u3 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .count(cnt3),
      .full(fu3), .empty(em3), .overflow(of3), .clr_ovf(clr_ovf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   task automatic push(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rstn = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0; clr_ovf = 1'b0;

      // Reset state
      do_reset();
      chk("rst_valid", ov2, 0);
      chk("rst_empty", em2, 1);
      chk("rst_full",  fu2, 0);
      chk("rst_data",  od2, 0);
      chk("rst_ovf",   of2, 0);
      chk("rst_count", cnt2, 0);

      // DECIM=2: 1..6 keeps 1,3,5
      for (int i = 1; i <= 6; i++) push(4'(i));
      chk("dec2_count", cnt2, 3);
      chk("dec2_head0", od2, 1);
      tick();
      chk("dec2_hold", od2, 1);
      out_ready = 1'b1;
      tick();
      chk("dec2_head1", od2, 3);
      chk("dec2_cnt2", cnt2, 2);
      tick();
      chk("dec2_head2", od2, 5);
      tick();
      chk("dec2_empty", em2, 1);
      chk("dec2_zero", od2, 0);

      // No bypass: push into empty with out_ready=1 does not pop
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 4'h5;
      #1;
      chk("lat_pre_valid", ov1, 0);
      tick();
      in_valid = 1'b0;
      chk("lat_valid", ov1, 1);
      chk("lat_count", cnt1, 1);
      chk("lat_data", od1, 5);
      tick();
      chk("lat_popped", em1, 1);
      out_ready = 1'b0;

      // DECIM=3 with idle gaps: 7,-1,2,-8 keeps 7 and -8
      do_reset();
      push(4'h7); tick();
      push(4'hF); tick();
      push(4'h2); tick();
      push(4'h8); tick();
      chk("gap_count", cnt3, 2);
      chk("gap_head0", od3, 4'h7);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("gap_head1", od3, 4'h8);

      // DECIM=1 overflow: nine samples, ninth dropped
      do_reset();
      for (int i = 1; i <= 9; i++) push(4'(i));
      chk("ovf_count", cnt1, 8);
      chk("ovf_full", fu1, 1);
      chk("ovf_flag", of1, 1);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("ovf_drain", od1, 32'(i));
         tick();
      end
      out_ready = 1'b0;
      chk("ovf_empty", em1, 1);
      chk("ovf_zero", od1, 0);
      chk("ovf_sticky", of1, 1);

      // Full with simultaneous pop reuses the freed entry
      do_reset();
      for (int i = 1; i <= 8; i++) push(4'(i));
      chk("fp_full_pre", fu1, 1);
      out_ready = 1'b1;
      push(4'hA);
      out_ready = 1'b0;
      chk("fp_count", cnt1, 8);
      chk("fp_head", od1, 2);
      chk("fp_ovf", of1, 0);

      // Clear/set collision: set wins, then clear alone
      clr_ovf = 1'b1;
      push(4'hB);
      chk("col_ovf", of1, 1);
      chk("col_count", cnt1, 8);
      tick();
      clr_ovf = 1'b0;
      chk("clr_ovf", of1, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("fp_drain", od1, (i < 7) ? 32'(i + 2) : 32'hA);
         tick();
      end
      out_ready = 1'b0;
      chk("fp_empty", em1, 1);

      // Reset mid-stream on DECIM=2 with count=5 and phase=1
      do_reset();
      for (int i = 1; i <= 9; i++) push(4'(i));
      chk("mid_count5", cnt2, 5);
      rstn     = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'hC;
      tick();
      rstn     = 1'b1;
      in_valid = 1'b0;
      chk("mid_count0", cnt2, 0);
      chk("mid_empty", em2, 1);
      chk("mid_valid", ov2, 0);
      push(4'h6);
      chk("mid_phase0_cnt", cnt2, 1);
      chk("mid_phase0_data", od2, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_decim_fifo.md
FIR_DECIM_FIFO -- requirements
Module: fir_decim_fifo

Interface
REQ-001 The block SHALL provide these parameters, one per line as name, default, meaning:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- DECIM, 2, decimation ratio; 1..15; 1 = keep every sample.

REQ-002 The block SHALL provide these ports, one per line as name, direction, width, meaning:
- clk, input, 1, single clock; all state updates on the rising edge.
- rstn, input, 1, reset; synchronous and active-low.
- in_valid, input, 1, in_data holds a new filter output sample this cycle.
- in_data, input, 4, signed filtered sample from the FIR output b.
- out_valid, output, 1, FIFO head is available.
- out_ready, input, 1, consumer accepts the head this cycle.
- out_data, output, 4, signed FIFO head sample.
- count, output, $clog2(DEPTH)+1, number of stored entries.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- overflow, output, 1, sticky flag for a dropped sample.
- clr_ovf, input, 1, clears overflow.

Function
REQ-003 The block SHALL hold a 4-bit decimation phase counter. On each cycle with in_valid=1, the counter SHALL advance 0,1,..,DECIM-1 and then wrap to 0. With in_valid=0 the counter SHALL hold.
REQ-004 A sample SHALL be "kept" only when in_valid=1 and phase==0 in that cycle. All other valid samples SHALL be discarded silently, with no flag.
REQ-005 With DECIM=1, phase SHALL remain 0 and every valid sample SHALL be kept.
REQ-006 A pop SHALL occur on a cycle where out_valid=1 and out_ready=1. A pop SHALL advance the read pointer by 1, modulo DEPTH.
REQ-007 A kept sample SHALL be written at the write pointer, and the write pointer SHALL advance modulo DEPTH, when either:
- full=0; or
- full=1 and a pop occurs in the same cycle (the freed entry is reused).
REQ-008 A kept sample arriving when full=1 with no pop in the same cycle SHALL be dropped, and overflow SHALL be set to 1 at that edge.
REQ-009 count SHALL change per cycle as follows:
- +1 on a write with no pop;
- -1 on a pop with no write;
- unchanged on a write with a simultaneous pop, or with neither.
REQ-010 The block SHALL NOT bypass an empty FIFO. A sample written at edge N SHALL first appear with out_valid=1 after edge N; minimum latency is 1 cycle.
REQ-011 A push into an empty FIFO with out_ready=1 SHALL NOT pop in that cycle, because out_valid=0.
REQ-012 out_valid SHALL equal !empty.
REQ-013 out_data SHALL equal the entry at the read pointer when out_valid=1, and SHALL be 4'b0000 when empty=1.
REQ-014 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 full and empty SHALL be decoded from count, with no extra cycle of latency.
REQ-016 clr_ovf=1 SHALL clear overflow at the next edge. If a drop occurs in the same cycle, set SHALL take priority and overflow SHALL be 1.
REQ-017 Stored samples SHALL be passed through bit-exact; the block SHALL perform no sign extension or arithmetic on in_data.

Reset
REQ-018 While rstn=0 at a rising edge, the block SHALL reset the read pointer, write pointer, phase and count to 0, and overflow to 0.
REQ-019 Immediately after reset, outputs SHALL be: out_valid=0, empty=1, full=0, out_data=0, overflow=0.
REQ-020 Storage array contents SHALL NOT be reset; they are unobservable while empty=1.
REQ-021 Reset asserted mid-operation SHALL discard all stored entries and the in-progress decimation phase. No pop or write SHALL occur on an edge where rstn=0.

Verification
REQ-022 Decimation, DECIM=2, out_ready=0: in_valid=1 with in_data 1,2,3,4,5,6 -> FIFO holds 1,3,5 and count=3.
REQ-023 Gapped input: in_valid alternating 1/0, DECIM=3, data 7,-1,2,-8 on the valid cycles -> 7 and -8 stored; phase is unaffected by the idle cycles.
REQ-024 Overflow, DEPTH=8, DECIM=1, out_ready=0: 9 valid samples -> count=8, full=1, overflow=1, and the 9th sample is absent. Then draining 8 entries -> first eight values in order, then empty=1 and out_data=0.
REQ-025 Full with a simultaneous pop: with the FIFO full, apply a kept sample together with out_ready=1 -> head popped, new sample written, count stays 8, overflow unchanged.
REQ-026 Clear/set collision: clr_ovf=1 in the same cycle as a drop -> overflow=1. Then clr_ovf=1 alone -> overflow=0 next cycle.
REQ-027 Reset mid-stream: with count=5, drive rstn=0 for 1 cycle -> count=0, empty=1, out_valid=0, and the next kept sample has phase 0.
